// File: rtl/fetch_unit.sv
// fetch_unit: in-order fetch, delay-slot branches, registered output.
// FETCH_PREFETCH_BUF_EN adds a one-entry buffer so fetch runs under stall.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic        rom_ready,
  input  logic [31:0] rom_rdata,
  output logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid
);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
`ifdef FETCH_PREFETCH_BUF_EN
  localparam logic [1:0] S_HOLD  = 2'd2;
`endif
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_pend_valid;
  logic [31:0] r_pend_addr;
`ifdef FETCH_PREFETCH_BUF_EN
  logic        r_buf_valid;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
`endif

  logic        w_done;
  logic        w_br;
  logic [31:0] w_npc;

`ifdef FETCH_PREFETCH_BUF_EN
  assign rom_en = (r_state == S_FETCH);
`else
  assign rom_en = (r_state == S_FETCH) & ~stall;
`endif

  assign w_done = rom_en & rom_ready;
  assign w_br   = branch_flag & r_valid & ~stall;
  assign w_npc  = r_pend_valid ? r_pend_addr :
                  w_br         ? branch_addr :
                                 r_pc + 32'd4;

  assign rom_addr   = r_pc;
  assign addr       = r_addr;
  assign inst       = r_inst;
  assign inst_valid = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_WAIT;
    end else begin
      case (r_state)
        S_WAIT:  r_state <= S_FETCH;
`ifdef FETCH_PREFETCH_BUF_EN
        S_FETCH: if (w_done & stall) r_state <= S_HOLD;
        S_HOLD:  if (!stall) r_state <= S_FETCH;
`else
        S_FETCH: r_state <= S_FETCH;
`endif
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // Branch without completion is remembered; the delay slot still issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 32'd0;
    end else if (w_done) begin
      r_pc         <= w_npc;
      r_pend_valid <= 1'b0;
    end else if (w_br) begin
`ifdef FETCH_PREFETCH_BUF_EN
      if (r_buf_valid) begin
        r_pc <= branch_addr;
      end else if (!r_pend_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= branch_addr;
      end
`else
      if (!r_pend_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= branch_addr;
      end
`endif
    end
  end

`ifdef FETCH_PREFETCH_BUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_pc    <= 32'd0;
      r_buf_inst  <= 32'd0;
    end else if (w_done & stall) begin
      r_buf_valid <= 1'b1;
      r_buf_pc    <= r_pc;
      r_buf_inst  <= rom_rdata;
    end else if (r_buf_valid & ~stall) begin
      r_buf_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 32'd0;
      r_inst  <= 32'd0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (w_done) begin
        r_addr  <= r_pc;
        r_inst  <= rom_rdata;
        r_valid <= 1'b1;
`ifdef FETCH_PREFETCH_BUF_EN
      end else if (r_buf_valid) begin
        r_addr  <= r_buf_pc;
        r_inst  <= r_buf_inst;
        r_valid <= 1'b1;
`endif
      end else begin
        r_inst  <= 32'd0;
        r_valid <= 1'b0;
      end
    end
  end

endmodule
